// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Ports: clk, rst (async, active-high), bus_addr/bus_we/bus_re/bus_wdata
//   (CPU data bus), bus_rdata (registered load data), uart_tx (serial line,
//   idle high), tx_busy (frame in flight or FIFO non-empty).
// Registers: BASE_ADDR = TXDATA (write pushes a byte, reads 0),
//   BASE_ADDR+4 = STATUS {28'b0, ovf, tx_busy, empty, full}; writing
//   bit 3 = 1 clears the sticky ovf flag.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [BW-1:0] BLAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [BW-1:0]   bcnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            ovf;

  logic            sel_tx;
  logic            sel_st;
  logic            wr_tx;
  logic            wr_st;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            bit_end;
  logic            idle_nxt;
  logic            busy_nxt;
  logic [31:0]     status;
  logic            unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  assign sel_tx  = (bus_addr == BASE_ADDR);
  assign sel_st  = (bus_addr == STAT_ADDR);
  assign wr_tx   = bus_we && sel_tx;
  assign wr_st   = bus_we && sel_st;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign bit_end = (bcnt == BLAST);

  // The FSM only pops from IDLE, so a pop frees a slot in the same
  // cycle and lets a store into a full FIFO through.
  assign pop  = (state == IDLE) && !empty;
  assign push = wr_tx && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Next-cycle view of the FSM, so tx_busy can be registered yet
  // still track the state it describes.
  assign idle_nxt = ((state == IDLE) && !pop)
                 || ((state == STOP) && bit_end);
  assign busy_nxt = !idle_nxt || (count_nxt != '0);

  assign status = {28'b0, ovf, tx_busy, empty, full};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count_nxt;
      tx_busy <= busy_nxt;
      if (wr_tx && !push) begin
        ovf <= 1'b1;
      end else if (wr_st && bus_wdata[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rdata <= '0;
    end else begin
      bus_rdata <= (bus_re && sel_st) ? status : '0;
    end
  end

  // uart_tx is loaded with the level of the state being entered, so
  // the line changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            bcnt    <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bcnt    <= '0;
            uart_tx <= shreg[0];
            state   <= DATA;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bcnt  <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              uart_tx <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bcnt    <= '0;
            uart_tx <= 1'b1;
            state   <= IDLE;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: self-checking bench for uart_tx_mmio
// (CLK_DIV=4, FIFO_DEPTH=4, BASE_ADDR=32'h1000_0000).
module tb_uart_tx_mmio;

  localparam logic [31:0] TXA = 32'h1000_0000;
  localparam logic [31:0] STA = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        uart_tx;
  logic        tx_busy;

  uart_tx_mmio #(
    .BASE_ADDR (TXA),
    .CLK_DIV   (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_addr (bus_addr),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int frame_err = 0;

  logic [7:0] expq[$];
  logic [7:0] rxq[$];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, tx_busy}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_rx(input string name);
    logic [7:0]  e;
    logic [31:0] a;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      if (rxq.size() > 0) begin
        a = {24'b0, rxq.pop_front()};
      end else begin
        a = 32'hFFFF_FFFF;
      end
      chk(name, a, {24'b0, e});
    end
    chk({name, "_extra"}, rxq.size(), 32'h0);
  endtask

  // Line receiver: samples the middle of every bit after a falling
  // edge; a frame disturbed by reset is discarded.
  logic [7:0] mon_b;
  logic       mon_ab;
  logic       mon_sb;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        mon_ab = 1'b0;
        mon_b  = '0;
        mon_sb = 1'b0;
        for (int t = 1; t <= 38; t++) begin
          @(negedge clk);
          if (rst) mon_ab = 1'b1;
          if (t == 2 && uart_tx !== 1'b0) mon_ab = 1'b1;
          if (t >= 6 && t <= 34 && (t - 6) % 4 == 0)
            mon_b[(t-6)/4] = uart_tx;
          if (t == 38) mon_sb = uart_tx;
        end
        if (!mon_ab) begin
          rxq.push_back(mon_b);
          if (mon_sb !== 1'b1) frame_err++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  pat;
    logic [7:0]  b;
    int          tries;

    vecs[0]  = '{STA, 1'b0, 32'h0, 1'b1, 32'h2};
    vecs[1]  = '{TXA, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[2]  = '{32'h1000_0008, 1'b1, 32'h41, 1'b1, 32'h0};
    vecs[3]  = '{STA, 1'b0, 32'h0, 1'b1, 32'h2};
    vecs[4]  = '{STA, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h2};
    vecs[5]  = '{32'h1000_0001, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[6]  = '{32'h0000_0004, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[7]  = '{STA, 1'b0, 32'h0, 1'b1, 32'h2};
    vecs[8]  = '{TXA, 1'b1, 32'h7E, 1'b1, 32'h0};
    vecs[9]  = '{STA, 1'b0, 32'h0, 1'b1, 32'h4};
    vecs[10] = '{STA, 1'b0, 32'h0, 1'b1, 32'h6};

    // Reset
    repeat (5) @(negedge clk);
    chk("rst_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_busy", {31'b0, tx_busy}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd(STA, d);
    chk("rst_status", d, 32'h2);

    // Register/decode vectors
    for (int i = 0; i < 11; i++) begin
      bus_addr  = vecs[i].addr;
      bus_we    = vecs[i].we;
      bus_wdata = vecs[i].wdata;
      bus_re    = vecs[i].re;
      @(negedge clk);
      bus_we = 1'b0;
      bus_re = 1'b0;
      if (vecs[i].re) chk($sformatf("vec%0d", i), bus_rdata, vecs[i].exp);
    end
    expq.push_back(8'h7E);
    wait_idle("vec_idle", 200);
    check_rx("vec_rx");

    // Single byte waveform
    pat = {1'b1, 8'h55, 1'b0};
    wr(TXA, 32'hFFFF_FF55);
    expq.push_back(8'h55);
    chk("sb_busy_on", {31'b0, tx_busy}, 32'h1);
    chk("sb_pre_line", {31'b0, uart_tx}, 32'h1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk($sformatf("sb_line%0d", c), {31'b0, uart_tx},
          {31'b0, pat[c/4]});
    end
    chk("sb_busy_last", {31'b0, tx_busy}, 32'h1);
    @(negedge clk);
    chk("sb_busy_off", {31'b0, tx_busy}, 32'h0);
    repeat (3) @(negedge clk);
    check_rx("sb_rx");

    // Overflow
    for (int i = 1; i <= 6; i++) begin
      wr(TXA, i);
      if (i <= 5) expq.push_back(8'(i));
    end
    rd(STA, d);
    chk("ovf_status", d, 32'hD);
    wait_idle("ovf_idle", 300);
    rd(STA, d);
    chk("ovf_sticky", d, 32'hA);
    wr(STA, 32'h8);
    rd(STA, d);
    chk("ovf_clear", d, 32'h2);
    check_rx("ovf_rx");

    // Push while full in the pop cycle
    wr(TXA, 32'h3C);
    expq.push_back(8'h3C);
    for (int i = 0; i < 4; i++) begin
      wr(TXA, 32'hC0 + i);
      expq.push_back(8'(8'hC0 + i));
    end
    repeat (37) @(negedge clk);
    wr(TXA, 32'hA5);
    expq.push_back(8'hA5);
    rd(STA, d);
    chk("popfull_status", d, 32'h5);
    wait_idle("popfull_idle", 400);
    rd(STA, d);
    chk("popfull_ovf", d, 32'h2);
    check_rx("popfull_rx");

    // Mid-frame reset during data bit 3
    wr(TXA, 32'h0F);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_tx", {31'b0, uart_tx}, 32'h1);
    chk("mrst_busy", {31'b0, tx_busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("mrst_busy_after", {31'b0, tx_busy}, 32'h0);
    rd(STA, d);
    chk("mrst_status", d, 32'h2);
    check_rx("mrst_rx");

    // Decode miss
    wr(32'h1000_0008, 32'h99);
    repeat (50) @(negedge clk);
    chk("dec_busy", {31'b0, tx_busy}, 32'h0);
    rd(32'h1000_0008, d);
    chk("dec_read", d, 32'h0);
    check_rx("dec_rx");

    // Random spaced bytes with status polling (pointer wrap)
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      tries = 0;
      do begin
        rd(STA, d);
        tries++;
      end while (d[0] && tries < 200);
      chk("rnd_poll", {31'b0, d[0]}, 32'h0);
      b = 8'($urandom);
      wr(TXA, {24'b0, b});
      expq.push_back(b);
    end
    wait_idle("rnd_idle", 1000);
    rd(STA, d);
    chk("rnd_status", d, 32'h2);
    check_rx("rnd_rx");
    chk("framing", frame_err, 32'h0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
